// File: rtl/tick_gen_pkg.sv
// Shared types and reset defaults for the fractional tick generator.
// Divisors are derived from the system clock and the UART/RTC target rates.
package tick_gen_pkg;

   localparam int unsigned TG_CNT_WIDTH    = 24;
   localparam int unsigned TG_FRAC_WIDTH   = 8;
   localparam int unsigned TG_MAX_CHANNELS = 8;

   localparam int unsigned CLK_FREQ = 20_000_000;
   localparam int unsigned BAUDRATE = 115_200;
   localparam int unsigned RTC_FREQ = 32_768;

   localparam int unsigned BAUD_DIV_INT  = CLK_FREQ / BAUDRATE;
   localparam int unsigned BAUD_DIV_FRAC = ((CLK_FREQ % BAUDRATE) * 256) / BAUDRATE;
   localparam int unsigned RTC_DIV_INT   = CLK_FREQ / RTC_FREQ;
   localparam int unsigned RTC_DIV_FRAC  = ((CLK_FREQ % RTC_FREQ) * 256) / RTC_FREQ;

   typedef struct packed {
      logic [TG_CNT_WIDTH-1:0]  period_int;
      logic [TG_FRAC_WIDTH-1:0] period_frac;
      logic                     en;
   } tick_cfg_t;

   localparam tick_cfg_t BAUD_CFG = '{period_int:  TG_CNT_WIDTH'(BAUD_DIV_INT),
                                      period_frac: TG_FRAC_WIDTH'(BAUD_DIV_FRAC),
                                      en:          1'b1};
   localparam tick_cfg_t RTC_CFG  = '{period_int:  TG_CNT_WIDTH'(RTC_DIV_INT),
                                      period_frac: TG_FRAC_WIDTH'(RTC_DIV_FRAC),
                                      en:          1'b1};
   localparam tick_cfg_t SPARE_CFG = '{period_int:  TG_CNT_WIDTH'(1),
                                       period_frac: '0,
                                       en:          1'b0};

   localparam tick_cfg_t TICK_CFG_RST [TG_MAX_CHANNELS] = '{
      BAUD_CFG, RTC_CFG, SPARE_CFG, SPARE_CFG,
      SPARE_CFG, SPARE_CFG, SPARE_CFG, SPARE_CFG
   };

endpackage

// File: rtl/tick_chan.sv
// One tick channel: pending/active config shadows, fractional phase
// accumulator and period down-counter producing a registered tick pulse.
module tick_chan
   import tick_gen_pkg::*;
#(
   parameter int unsigned CNT_WIDTH  = TG_CNT_WIDTH,
   parameter int unsigned FRAC_WIDTH = TG_FRAC_WIDTH,
   parameter tick_cfg_t   RST_CFG    = SPARE_CFG
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cfg_wr_i,
   input  logic [CNT_WIDTH-1:0]  cfg_int_i,
   input  logic [FRAC_WIDTH-1:0] cfg_frac_i,
   input  logic                  cfg_en_i,
   input  logic                  restart_i,
   output logic                  tick_o
);

   localparam logic [CNT_WIDTH-1:0]  RST_INT  = CNT_WIDTH'(RST_CFG.period_int);
   localparam logic [FRAC_WIDTH-1:0] RST_FRAC = FRAC_WIDTH'(RST_CFG.period_frac);
   localparam logic [CNT_WIDTH-1:0]  RST_CNT  =
      (!RST_CFG.en || RST_INT == '0) ? '0 : RST_INT - CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0]  pend_int_q, pend_int_d, act_int_q, act_int_d, cnt_q, cnt_d;
   logic [FRAC_WIDTH-1:0] pend_frac_q, pend_frac_d, act_frac_q, act_frac_d, acc_q, acc_d;
   logic                  pend_en_q, pend_en_d, act_en_q, act_en_d, tick_q, tick_d;
   logic [CNT_WIDTH-1:0]  pend_m1;
   logic [FRAC_WIDTH:0]   sum;

   // int==0 behaves as int==1, so both reload the counter with 0
   assign pend_m1 = (pend_int_q == '0) ? '0 : pend_int_q - CNT_WIDTH'(1);
   assign sum     = {1'b0, acc_q} + {1'b0, pend_frac_q};

   always_comb begin
      pend_int_d  = pend_int_q;
      pend_frac_d = pend_frac_q;
      pend_en_d   = pend_en_q;
      if (cfg_wr_i) begin
         pend_int_d  = cfg_int_i;
         pend_frac_d = cfg_frac_i;
         pend_en_d   = cfg_en_i;
      end

      act_int_d  = act_int_q;
      act_frac_d = act_frac_q;
      act_en_d   = act_en_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      tick_d     = 1'b0;

      if (!act_en_q) begin
         act_int_d  = pend_int_q;
         act_frac_d = pend_frac_q;
         act_en_d   = pend_en_q;
         acc_d      = '0;
         cnt_d      = pend_en_q ? pend_m1 : '0;
      end else if (restart_i) begin
         cnt_d = act_int_q >> 1;
         acc_d = '0;
      end else if (cnt_q == '0) begin
         // boundary: the pending copy becomes active and sizes the next period
         tick_d     = 1'b1;
         act_int_d  = pend_int_q;
         act_frac_d = pend_frac_q;
         act_en_d   = pend_en_q;
         if (pend_en_q) begin
            cnt_d = pend_m1 + CNT_WIDTH'(sum[FRAC_WIDTH]);
            acc_d = sum[FRAC_WIDTH-1:0];
         end else begin
            cnt_d = '0;
            acc_d = '0;
         end
      end else begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_int_q  <= RST_INT;
         pend_frac_q <= RST_FRAC;
         pend_en_q   <= RST_CFG.en;
         act_int_q   <= RST_INT;
         act_frac_q  <= RST_FRAC;
         act_en_q    <= RST_CFG.en;
         cnt_q       <= RST_CNT;
         acc_q       <= '0;
         tick_q      <= 1'b0;
      end else begin
         pend_int_q  <= pend_int_d;
         pend_frac_q <= pend_frac_d;
         pend_en_q   <= pend_en_d;
         act_int_q   <= act_int_d;
         act_frac_q  <= act_frac_d;
         act_en_q    <= act_en_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         tick_q      <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel fractional clock-enable generator: decodes the config
// strobe to one channel and instantiates one tick_chan per channel.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int unsigned  CHANNELS   = 2,
   parameter int unsigned  CNT_WIDTH  = TG_CNT_WIDTH,
   parameter int unsigned  FRAC_WIDTH = TG_FRAC_WIDTH,
   localparam int unsigned CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cfg_valid,
   input  logic [CHAN_W-1:0]     cfg_chan,
   input  logic [CNT_WIDTH-1:0]  cfg_int,
   input  logic [FRAC_WIDTH-1:0] cfg_frac,
   input  logic                  cfg_en,
   input  logic [CHANNELS-1:0]   restart,
   output logic [CHANNELS-1:0]   tick
);

   // out-of-range channel indices match no instance and are dropped
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic cfg_wr;
      assign cfg_wr = cfg_valid && (cfg_chan == CHAN_W'(i));

      tick_chan #(
         .CNT_WIDTH  (CNT_WIDTH),
         .FRAC_WIDTH (FRAC_WIDTH),
         .RST_CFG    (TICK_CFG_RST[i])
      ) u_chan (
         .clk_i      (clock),
         .rst_ni     (reset),
         .cfg_wr_i   (cfg_wr),
         .cfg_int_i  (cfg_int),
         .cfg_frac_i (cfg_frac),
         .cfg_en_i   (cfg_en),
         .restart_i  (restart[i]),
         .tick_o     (tick[i])
      );
   end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: an absolute-time reference model predicts
// tick cycles into per-channel queues, a monitor pops them as ticks appear.
module tb_tick_gen;

   localparam int unsigned NCH = 3;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           cfg_valid = 1'b0;
   logic [1:0]     cfg_chan = '0;
   logic [23:0]    cfg_int = '0;
   logic [7:0]     cfg_frac = '0;
   logic           cfg_en = 1'b0;
   logic [NCH-1:0] restart = '0;
   logic [NCH-1:0] tick;

   tick_gen #(.CHANNELS(NCH), .CNT_WIDTH(24), .FRAC_WIDTH(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_chan  (cfg_chan),
      .cfg_int   (cfg_int),
      .cfg_frac  (cfg_frac),
      .cfg_en    (cfg_en),
      .restart   (restart),
      .tick      (tick)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   int unsigned m_pi [NCH], m_pf [NCH], m_ai [NCH], m_af [NCH];
   bit          m_pe [NCH], m_ae [NCH];
   int unsigned m_acc [NCH], m_next [NCH];
   int unsigned exp_q [NCH][$];
   int unsigned obs_q [NCH][$];
   int unsigned oi, of, s;
   bit          oe;

   function automatic int unsigned eff(int unsigned i);
      return (i == 0) ? 1 : i;
   endfunction

   function void model_reset();
      for (int ch = 0; ch < NCH; ch++) begin
         case (ch)
            0:       begin m_pi[ch] = 173; m_pf[ch] = 156; m_pe[ch] = 1'b1; end
            1:       begin m_pi[ch] = 610; m_pf[ch] = 90;  m_pe[ch] = 1'b1; end
            default: begin m_pi[ch] = 1;   m_pf[ch] = 0;   m_pe[ch] = 1'b0; end
         endcase
         m_ai[ch] = m_pi[ch]; m_af[ch] = m_pf[ch]; m_ae[ch] = m_pe[ch];
         m_acc[ch]  = 0;
         m_next[ch] = m_pi[ch];
         exp_q[ch].delete();
         obs_q[ch].delete();
      end
      cyc = 0;
   endfunction

   // Reference model: tracks the absolute cycle of each channel's next tick.
   always @(posedge clock) begin
      if (!reset) model_reset();
      else begin
         cyc++;
         for (int ch = 0; ch < NCH; ch++) begin
            oi = m_pi[ch]; of = m_pf[ch]; oe = m_pe[ch];
            if (cfg_valid && cfg_chan == ch) begin
               m_pi[ch] = cfg_int; m_pf[ch] = cfg_frac; m_pe[ch] = cfg_en;
            end
            if (!m_ae[ch]) begin
               m_ai[ch] = oi; m_af[ch] = of; m_ae[ch] = oe; m_acc[ch] = 0;
               if (oe) m_next[ch] = cyc + eff(oi);
            end else if (restart[ch]) begin
               m_next[ch] = cyc + m_ai[ch] / 2 + 1;
               m_acc[ch]  = 0;
            end else if (cyc == m_next[ch]) begin
               exp_q[ch].push_back(cyc);
               m_ai[ch] = oi; m_af[ch] = of; m_ae[ch] = oe;
               if (oe) begin
                  s = m_acc[ch] + of;
                  m_next[ch] = cyc + eff(oi) + s / 256;
                  m_acc[ch]  = s % 256;
               end else m_acc[ch] = 0;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         checks++;
         if (tick !== '0) begin
            errors++;
            $display("FAIL tick_in_reset got %b expected 000", tick);
         end
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            while (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
               checks++; errors++;
               $display("FAIL missing_tick ch%0d got none expected tick at cycle %0d", ch, exp_q[ch][0]);
               void'(exp_q[ch].pop_front());
            end
            if (tick[ch] !== 1'b0) begin
               checks++;
               obs_q[ch].push_back(cyc);
               if (tick[ch] !== 1'b1 || exp_q[ch].size() == 0 || exp_q[ch][0] != cyc) begin
                  errors++;
                  $display("FAIL unexpected_tick ch%0d got tick=%b at cycle %0d expected next at %0d",
                           ch, tick[ch], cyc, (exp_q[ch].size() > 0) ? exp_q[ch][0] : 0);
               end else void'(exp_q[ch].pop_front());
            end
         end
      end
   end

   task automatic chk(string name, int unsigned act, int unsigned expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic int unsigned obs_at(int ch, int idx);
      if (idx < 0 || idx >= obs_q[ch].size()) return 32'hFFFF_FFFF;
      return obs_q[ch][idx];
   endfunction

   function automatic int unsigned first_after(int ch, int unsigned t);
      for (int k = 0; k < obs_q[ch].size(); k++)
         if (obs_q[ch][k] > t) return obs_q[ch][k];
      return 32'hFFFF_FFFF;
   endfunction

   function automatic int idx_of(int ch, int unsigned t);
      for (int k = 0; k < obs_q[ch].size(); k++)
         if (obs_q[ch][k] == t) return k;
      return -1;
   endfunction

   // Called at a negedge; the write is sampled on the following posedge.
   task automatic cfg_write(int unsigned ch, int unsigned i, int unsigned f, bit en,
                            output int unsigned wedge);
      cfg_chan = 2'(ch); cfg_int = 24'(i); cfg_frac = 8'(f); cfg_en = en;
      cfg_valid = 1'b1;
      wedge = cyc + 1;
      @(negedge clock);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_boundary(int ch, int unsigned lead);
      for (int n = 0; n < 1000 && m_next[ch] != cyc + lead; n++) @(negedge clock);
      chk("boundary_reached", (m_next[ch] == cyc + lead) ? 1 : 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int unsigned w, bnd, r, g1, g2, g3, g4, cnt174, cnt;
      int          k;

      repeat (3) @(negedge clock);
      reset = 1'b1;

      // default rates: UART and RTC channels out of reset
      for (int n = 0; n < 46000 && obs_q[0].size() < 257; n++) @(negedge clock);
      chk("ch0_first_tick", obs_at(0, 0), 173);
      chk("ch1_first_tick", obs_at(1, 0), 610);
      chk("ch0_256_period_span", obs_at(0, 256) - obs_at(0, 0), 44444);
      cnt174 = 0;
      for (int n = 0; n < 256; n++)
         if (obs_at(0, n + 1) - obs_at(0, n) == 174) cnt174++;
      chk("ch0_long_gaps", cnt174, 156);
      chk("ch1_64_period_span", obs_at(1, 64) - obs_at(1, 0), 39062);
      chk("ch2_idle", obs_q[2].size(), 0);

      // enable spare channel, then period 0
      cfg_write(2, 4, 0, 1'b1, w);
      repeat (30) @(negedge clock);
      chk("ch2_first_tick", obs_at(2, 0), w + 5);
      chk("ch2_period4", obs_at(2, 1) - obs_at(2, 0), 4);
      cfg_write(2, 0, 0, 1'b1, w);
      repeat (20) @(negedge clock);
      chk("ch2_continuous", obs_at(2, obs_q[2].size() - 1) - obs_at(2, obs_q[2].size() - 5), 4);

      // write coinciding with a ch0 boundary
      wait_boundary(0, 1);
      bnd = cyc + 1;
      cfg_write(0, 10, 128, 1'b1, w);
      repeat (250) @(negedge clock);
      k = idx_of(0, bnd);
      chk("t3_boundary_found", (k >= 0 && k + 4 < obs_q[0].size()) ? 1 : 0, 1);
      if (k >= 0 && k + 4 < obs_q[0].size()) begin
         g1 = obs_q[0][k+1] - obs_q[0][k];
         g2 = obs_q[0][k+2] - obs_q[0][k+1];
         g3 = obs_q[0][k+3] - obs_q[0][k+2];
         g4 = obs_q[0][k+4] - obs_q[0][k+3];
         chk("t3_old_period", (g1 == 173 || g1 == 174) ? 1 : 0, 1);
         chk("t3_pair_a", g2 + g3, 21);
         chk("t3_pair_b", g3 + g4, 21);
         chk("t3_alternate", (g2 != g3) ? 1 : 0, 1);
      end

      // restart mid-period and on a boundary
      cfg_write(0, 173, 156, 1'b1, w);
      repeat (200) @(negedge clock);
      for (int n = 0; n < 400 && m_next[0] < cyc + 20; n++) @(negedge clock);
      restart[0] = 1'b1; r = cyc + 1;
      @(negedge clock); restart[0] = 1'b0;
      repeat (100) @(negedge clock);
      chk("restart_mid", first_after(0, r) - r, 87);
      wait_boundary(0, 1);
      restart[0] = 1'b1; r = cyc + 1;
      @(negedge clock); restart[0] = 1'b0;
      repeat (100) @(negedge clock);
      chk("restart_boundary_suppressed", (idx_of(0, r) < 0) ? 1 : 0, 1);
      chk("restart_boundary_next", first_after(0, r) - r, 87);

      // disable ch1: one tick still due, then silence
      if (m_next[1] == cyc + 1) @(negedge clock);
      cfg_write(1, 610, 90, 1'b0, w);
      repeat (1300) @(negedge clock);
      cnt = 0;
      foreach (obs_q[1][n]) if (obs_q[1][n] > w) cnt++;
      chk("ch1_disable_ticks", cnt, 1);

      // out-of-range channel index changes nothing
      cfg_write(3, 1, 0, 1'b0, w);
      cfg_write(3, 0, 255, 1'b1, w);
      repeat (400) @(negedge clock);
      chk("ch1_still_off", first_after(1, w), 32'hFFFF_FFFF);

      // reset mid-count
      @(negedge clock);
      #2 reset = 1'b0;
      #1 chk("async_reset_tick", 32'(tick), 0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (700) @(negedge clock);
      chk("post_reset_ch0", obs_at(0, 0), 173);
      chk("post_reset_ch1", obs_at(1, 0), 610);

      // random configs, channels (incl. out of range) and restarts
      for (int n = 0; n < 4000; n++) begin
         cfg_valid = ($urandom_range(0, 19) == 0);
         cfg_chan  = 2'($urandom_range(0, 3));
         cfg_int   = 24'($urandom_range(0, 12));
         cfg_frac  = 8'($urandom);
         cfg_en    = ($urandom_range(0, 3) != 0);
         for (int ch = 0; ch < NCH; ch++) restart[ch] = ($urandom_range(0, 29) == 0);
         @(negedge clock);
      end
      cfg_valid = 1'b0;
      restart   = '0;
      repeat (40) @(negedge clock);
      #1;
      cnt = 0;
      for (int ch = 0; ch < NCH; ch++) cnt += exp_q[ch].size();
      chk("scoreboard_drained", cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
